// File: rtl/fact_ctrl_if.sv
// Bundles the operation request/response and multiplier handshake signals of the
// factorial sequencer. The master side is the sequencer; the slave side is its environment.
interface fact_ctrl_if #(
  parameter int W = 64
);
  logic           op_start;
  logic           op_clear;
  logic [W-1:0]   n_value;
  logic           mul_start;
  logic           mul_clear;
  logic [W-1:0]   mul_multiplier;
  logic [W-1:0]   mul_multiplicand;
  logic           mul_done;
  logic [2*W-1:0] mul_result;
  logic [2*W-1:0] fac_result;
  logic           op_done;
  logic           busy;
  logic           overflow;

  modport master (
    input  op_start, op_clear, n_value, mul_done, mul_result,
    output mul_start, mul_clear, mul_multiplier, mul_multiplicand,
           fac_result, op_done, busy, overflow
  );

  modport slave (
    output op_start, op_clear, n_value, mul_done, mul_result,
    input  mul_start, mul_clear, mul_multiplier, mul_multiplicand,
           fac_result, op_done, busy, overflow
  );
endinterface

// File: rtl/fact_ctrl.sv
// Factorial sequencer: drives a Booth multiplier with (acc, count) pairs and folds
// each product back into acc until the multiplier operand 1 has been applied.
module fact_ctrl #(
  parameter int W     = 64,
  parameter int N_MAX = 20
) (
  input  logic        clk,
  input  logic        reset_n,
  fact_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_MUL_CLR,
    S_DONE
  } state_t;

  state_t         r_state,     w_state;
  logic [W-1:0]   r_acc,       w_acc;
  logic [W-1:0]   r_cnt,       w_cnt;
  logic           r_mul_start, w_mul_start;
  logic           r_mul_clear, w_mul_clear;
  logic [W-1:0]   r_mcand,     w_mcand;
  logic [W-1:0]   r_mplier,    w_mplier;
  logic [2*W-1:0] r_fac,       w_fac;
  logic           r_op_done,   w_op_done;
  logic           r_busy,      w_busy;
  logic           r_ovf,       w_ovf;

  always_comb begin
    // NOTE: every next value defaults to its register (pulses to 0) before any branch, so no latch can be inferred.
    w_state     = r_state;
    w_acc       = r_acc;
    w_cnt       = r_cnt;
    w_mul_start = 1'b0;
    w_mul_clear = 1'b0;
    w_mcand     = r_mcand;
    w_mplier    = r_mplier;
    w_fac       = r_fac;
    w_op_done   = r_op_done;
    w_ovf       = r_ovf;

    if (bus.op_clear) begin
      w_state     = S_IDLE;
      w_mul_clear = 1'b1;
      w_op_done   = 1'b0;
      w_ovf       = 1'b0;
      w_fac       = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.op_start) begin
            w_cnt       = bus.n_value;
            w_mul_clear = 1'b1;
            w_state     = S_CHECK;
          end
        end
        S_CHECK: begin
          if (r_cnt > W'(N_MAX)) begin
            w_fac     = '0;
            w_ovf     = 1'b1;
            w_op_done = 1'b1;
            w_state   = S_DONE;
          end else if (r_cnt <= W'(1)) begin
            w_fac     = (2*W)'(1);
            w_op_done = 1'b1;
            w_state   = S_DONE;
          end else begin
            w_acc   = r_cnt;
            w_cnt   = r_cnt - W'(1);
            w_state = S_MUL_REQ;
          end
        end
        S_MUL_REQ: begin
          w_mcand     = r_acc;
          w_mplier    = r_cnt;
          w_mul_start = 1'b1;
          w_state     = S_MUL_WAIT;
        end
        S_MUL_WAIT: begin
          if (bus.mul_done) begin
            // Anything above bit W-2 means the product left the positive signed range.
            if (|bus.mul_result[2*W-1:W-1]) begin
              w_ovf     = 1'b1;
              w_fac     = bus.mul_result;
              w_op_done = 1'b1;
              w_state   = S_DONE;
            end else begin
              w_acc       = bus.mul_result[W-1:0];
              w_cnt       = r_cnt - W'(1);
              w_mul_clear = 1'b1;
              w_state     = S_MUL_CLR;
            end
          end
        end
        S_MUL_CLR: begin
          // cnt reaches 0 only after the operand 1 has been multiplied in.
          if (r_cnt == '0) begin
            w_fac     = {{W{1'b0}}, r_acc};
            w_op_done = 1'b1;
            w_state   = S_DONE;
          end else begin
            w_state = S_MUL_REQ;
          end
        end
        S_DONE: begin
          w_state = S_DONE;
        end
        default: begin
          w_state = S_IDLE;
        end
      endcase
    end

    w_busy = (w_state != S_IDLE) && (w_state != S_DONE);
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is tested inside the clocked block, making it synchronous; all state uses non-blocking assignments.
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_mul_start <= 1'b0;
      r_mul_clear <= 1'b0;
      r_mcand     <= '0;
      r_mplier    <= '0;
      r_fac       <= '0;
      r_op_done   <= 1'b0;
      r_busy      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_acc       <= w_acc;
      r_cnt       <= w_cnt;
      r_mul_start <= w_mul_start;
      r_mul_clear <= w_mul_clear;
      r_mcand     <= w_mcand;
      r_mplier    <= w_mplier;
      r_fac       <= w_fac;
      r_op_done   <= w_op_done;
      r_busy      <= w_busy;
      r_ovf       <= w_ovf;
    end
  end

  assign bus.mul_start        = r_mul_start;
  assign bus.mul_clear        = r_mul_clear;
  assign bus.mul_multiplicand = r_mcand;
  assign bus.mul_multiplier   = r_mplier;
  assign bus.fac_result       = r_fac;
  assign bus.op_done          = r_op_done;
  assign bus.busy             = r_busy;
  assign bus.overflow         = r_ovf;

endmodule

// File: tb/tb_fact_ctrl.sv
// Bench for fact_ctrl: behavioural Booth-multiplier stand-in, directed vector table,
// randomized n against a plain-arithmetic factorial model, and abort/spurious-done sequences.
module tb_fact_ctrl;
  localparam int W = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fact_ctrl_if #(.W(W)) bus ();

  fact_ctrl #(.W(W), .N_MAX(20)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Multiplier stand-in: signed product after t_mul edges, done held until mul_clear.
  int             t_mul = 2;
  logic           m_done, m_busy, spur_done;
  int             m_left;
  logic [2*W-1:0] m_prod, m_result;

  function automatic logic [2*W-1:0] mul_model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb;
    sa = $signed({{W{a[W-1]}}, a});
    sb = $signed({{W{b[W-1]}}, b});
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_done <= 1'b0; m_busy <= 1'b0; m_left <= 0; m_prod <= '0; m_result <= '0;
    end else if (bus.mul_clear) begin
      m_done <= 1'b0; m_busy <= 1'b0;
    end else if (bus.mul_start) begin
      m_busy <= 1'b1;
      m_left <= t_mul;
      m_prod <= mul_model(bus.mul_multiplicand, bus.mul_multiplier);
    end else if (m_busy) begin
      if (m_left <= 1) begin
        m_done <= 1'b1; m_busy <= 1'b0; m_result <= m_prod;
      end else begin
        m_left <= m_left - 1;
      end
    end
  end

  assign bus.mul_done   = m_done | spur_done;
  assign bus.mul_result = spur_done ? {2*W{1'b1}} : m_result;

  // Monitor: counts pulses and logs operands at every mul_start.
  int             n_starts = 0, n_clears = 0, n_overlap = 0;
  logic [2*W-1:0] obs_q[$];
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.mul_start) begin
        n_starts++;
        obs_q.push_back({bus.mul_multiplicand, bus.mul_multiplier});
      end
      if (bus.mul_clear) n_clears++;
      if (bus.mul_start && bus.mul_clear) n_overlap++;
    end
  end

  // Reference: n! by plain multiplication; products applied are n*(n-1)*...*1 => n-1 of them.
  function automatic void fact_ref(input logic [W-1:0] n, output logic [2*W-1:0] f,
                                   output bit ovf, output int prods);
    longint unsigned p = 1;
    if (n > 64'd20) begin
      f = '0; ovf = 1'b1; prods = 0;
    end else begin
      for (int k = 2; k <= int'(n); k++) p = p * longint'(k);
      f = {{W{1'b0}}, p};
      ovf = 1'b0;
      prods = (n >= 64'd2) ? int'(n) - 1 : 0;
    end
  endfunction

  task automatic run_op(input string name, input logic [W-1:0] n, input logic [2*W-1:0] exp_fac,
                        input bit exp_ovf, input int exp_prods);
    int s0, c0, q0, cyc;
    logic [W-1:0] acc;
    s0 = n_starts; c0 = n_clears; q0 = obs_q.size();
    bus.n_value  = n;
    bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    cyc = 1;
    while (!bus.op_done && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check({name, "_done"}, bus.op_done, 1'b1);
    check({name, "_fac"}, bus.fac_result, exp_fac);
    check({name, "_ovf"}, bus.overflow, exp_ovf);
    check({name, "_busy"}, bus.busy, 1'b0);
    check({name, "_starts"}, n_starts - s0, exp_prods);
    check({name, "_clears"}, n_clears - c0, 1 + exp_prods);
    if (exp_prods == 0) check({name, "_latency"}, cyc, 2);
    acc = n;
    for (int i = 0; i < exp_prods; i++) begin
      logic [W-1:0] k;
      k = n - W'(1) - W'(i);
      if (q0 + i < obs_q.size()) check({name, "_operands"}, obs_q[q0 + i], {acc, k});
      else check({name, "_operand_missing"}, 1'b0, 1'b1);
      acc = acc * k;
    end
    bus.op_start = 1'b1;
    repeat (2) @(negedge clk);
    bus.op_start = 1'b0;
    check({name, "_hold_start_ignored"}, bus.fac_result, exp_fac);
    bus.op_clear = 1'b1;
    @(negedge clk);
    check({name, "_clr_done"}, bus.op_done, 1'b0);
    check({name, "_clr_fac"}, bus.fac_result, '0);
    check({name, "_clr_ovf"}, bus.overflow, 1'b0);
    check({name, "_clr_mulclear"}, bus.mul_clear, 1'b1);
    bus.op_clear = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [W-1:0]   n;
    logic [2*W-1:0] exp_fac;
    bit             exp_ovf;
    int             exp_prods;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [2*W-1:0] rf;
    bit             ro;
    int             rp, rises, cyc;
    logic           prev;

    vecs[0] = '{64'd0,  128'd1, 1'b0, 0};
    vecs[1] = '{64'd1,  128'd1, 1'b0, 0};
    vecs[2] = '{64'd2,  128'd2, 1'b0, 1};
    vecs[3] = '{64'd5,  128'd120, 1'b0, 4};
    vecs[4] = '{64'd20, 128'h21C3677C82B40000, 1'b0, 19};
    vecs[5] = '{64'd21, 128'd0, 1'b1, 0};
    vecs[6] = '{64'h8000_0000_0000_0005, 128'd0, 1'b1, 0};
    vecs[7] = '{64'd7,  128'd5040, 1'b0, 6};

    spur_done    = 1'b0;
    bus.op_start = 1'b1;
    bus.op_clear = 1'b0;
    bus.n_value  = 64'd5;
    reset_n      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_outputs", {bus.mul_start, bus.mul_clear, bus.op_done, bus.busy, bus.overflow}, '0);
    check("rst_operands", {bus.mul_multiplicand, bus.mul_multiplier}, '0);
    check("rst_fac", bus.fac_result, '0);
    bus.op_start = 1'b0;
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_rst", {bus.busy, bus.op_done, bus.mul_start, bus.mul_clear}, '0);

    for (int i = 0; i < 8; i++) begin
      t_mul = 1 + (i % 3);
      run_op($sformatf("vec%0d", i), vecs[i].n, vecs[i].exp_fac, vecs[i].exp_ovf, vecs[i].exp_prods);
    end

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] n;
      n = W'($urandom_range(0, 24));
      t_mul = int'($urandom_range(1, 5));
      fact_ref(n, rf, ro, rp);
      run_op($sformatf("rand%0d_n%0d", i, n), n, rf, ro, rp);
    end

    // Abort: op_clear lands on the same edge that would capture the third product.
    t_mul = 3;
    bus.n_value  = 64'd10;
    bus.op_start = 1'b1;
    @(negedge clk);
    bus.op_start = 1'b0;
    rises = 0; prev = 1'b0; cyc = 0;
    while (rises < 3 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (bus.mul_done && !prev) rises++;
      prev = bus.mul_done;
    end
    check("abort_reached_done", rises, 3);
    check("abort_busy_before", bus.busy, 1'b1);
    bus.op_clear = 1'b1;
    @(negedge clk);
    bus.op_clear = 1'b0;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_mulclear", bus.mul_clear, 1'b1);
    check("abort_opdone", bus.op_done, 1'b0);
    check("abort_mulstart", bus.mul_start, 1'b0);
    check("abort_fac", bus.fac_result, '0);
    repeat (2) @(negedge clk);

    spur_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("spurious_idle", {bus.busy, bus.op_done, bus.mul_start, bus.mul_clear, bus.overflow}, '0);
    end
    spur_done = 1'b0;
    @(negedge clk);

    t_mul = 2;
    run_op("after_abort_n3", 64'd3, 128'd6, 1'b0, 2);

    check("start_clear_never_overlap", n_overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
